// File: rtl/core_mon_pkg.sv
// Shared types and constants for the core run monitor.
//   mon_state_t  : monitor run state (IDLE / RUN / HALTED)
//   halt_cause_t : reason for the last halt, encoded as seen on halt_cause
//   EBREAK_INST  : RV32 encoding of the ebreak instruction
package core_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } mon_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_EBREAK  = 2'd1,
    CAUSE_BKPT    = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } halt_cause_t;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/mon_trace_fifo.sv
// Overwrite-on-full circular trace buffer.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (buffer becomes empty)
//   push        : write push_data this cycle
//   push_data   : value to store
//   pop         : drop the oldest entry (ignored when empty)
//   rd_data     : oldest entry, first-word fall-through, 0 when empty
//   count       : number of entries held (0..DEPTH)
//   overflow    : sticky, set when a push overwrote an unread entry
module mon_trace_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          full;
  logic          do_pop;

  assign full   = (count == CNT_FULL);
  assign do_pop = pop && (count != '0);

  assign rd_data = (count == '0) ? '0 : mem[head];

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  // When full, tail == head, so a push lands on the oldest slot; advancing
  // head with it discards that entry whether or not a pop is also present.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (do_pop || (push && full)) head <= head + PTR_ONE;
      if (push && full && !do_pop) overflow <= 1'b1;
      if (push && !do_pop && !full) count <= count + CNT_ONE;
      else if (do_pop && !push)     count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/core_run_monitor.sv
// Run-control and trace monitor for the RISC-V core.
// Halts the run on ebreak, a programmable PC breakpoint or a cycle timeout,
// and keeps a circular trace of the most recent fetched PCs.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   pc_valid, pc, inst           : core fetch stream
//   run_start                    : start from IDLE / resume from HALTED
//   bkpt_we/idx/addr/en          : breakpoint slot programming
//   timeout_limit                : RUN-cycle limit, 0 disables
//   running, halt                : state is RUN / HALTED
//   halt_cause/idx/pc            : captured halt reason
//   cycle_cnt                    : saturating RUN cycles since start/resume
//   trace_rd_en/rd_data/count    : trace pop, oldest entry, fill level
//   trace_overflow               : sticky trace overwrite flag
module core_run_monitor
  import core_mon_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_BKPT    = 4,
  parameter int TRACE_DEPTH = 16,
  parameter int TIMEOUT_W   = 16,
  localparam int IW         = (NUM_BKPT > 1) ? $clog2(NUM_BKPT) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pc_valid,
  input  logic [XLEN-1:0]              pc,
  input  logic [XLEN-1:0]              inst,
  input  logic                         run_start,
  input  logic                         bkpt_we,
  input  logic [IW-1:0]                bkpt_idx,
  input  logic [XLEN-1:0]              bkpt_addr,
  input  logic                         bkpt_en,
  input  logic [TIMEOUT_W-1:0]         timeout_limit,
  output logic                         running,
  output logic                         halt,
  output logic [1:0]                   halt_cause,
  output logic [IW-1:0]                halt_idx,
  output logic [XLEN-1:0]              halt_pc,
  output logic [TIMEOUT_W-1:0]         cycle_cnt,
  input  logic                         trace_rd_en,
  output logic [XLEN-1:0]              trace_rd_data,
  output logic [$clog2(TRACE_DEPTH):0] trace_count,
  output logic                         trace_overflow
);

  // Slot storage is sized to the full index range so any bkpt_idx value is a
  // legal write target; only the first NUM_BKPT slots take part in matching.
  localparam int NUM_SLOTS = 1 << IW;
  localparam logic [XLEN-1:0]      EBREAK_X = XLEN'(EBREAK_INST);
  localparam logic [TIMEOUT_W-1:0] CNT_ONE  = TIMEOUT_W'(1);

  mon_state_t      state;
  logic [XLEN-1:0] bkpt_addr_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] bkpt_en_q;

  logic            ebreak_hit;
  logic            bkpt_hit;
  logic [IW-1:0]   bkpt_hit_idx;
  logic            timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      bkpt_en_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) bkpt_addr_q[i] <= '0;
    end else if (bkpt_we) begin
      bkpt_addr_q[bkpt_idx] <= bkpt_addr;
      bkpt_en_q[bkpt_idx]   <= bkpt_en;
    end
  end

  assign ebreak_hit  = pc_valid && (inst == EBREAK_X);
  assign timeout_hit = (timeout_limit != '0) && (cycle_cnt == timeout_limit - CNT_ONE);

  // Scan from the top so the lowest matching slot is the one left standing.
  always_comb begin
    bkpt_hit     = 1'b0;
    bkpt_hit_idx = '0;
    for (int i = NUM_BKPT - 1; i >= 0; i--) begin
      if (pc_valid && bkpt_en_q[i] && (pc == bkpt_addr_q[i])) begin
        bkpt_hit     = 1'b1;
        bkpt_hit_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      running    <= 1'b0;
      halt       <= 1'b0;
      halt_cause <= CAUSE_NONE;
      halt_idx   <= '0;
      halt_pc    <= '0;
      cycle_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (run_start) begin
            state      <= ST_RUN;
            running    <= 1'b1;
            halt       <= 1'b0;
            halt_cause <= CAUSE_NONE;
            halt_idx   <= '0;
            halt_pc    <= '0;
            cycle_cnt  <= '0;
          end
        end
        ST_RUN: begin
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_ONE;
          if (ebreak_hit || bkpt_hit || timeout_hit) begin
            state   <= ST_HALTED;
            running <= 1'b0;
            halt    <= 1'b1;
          end
          if (ebreak_hit) begin
            halt_cause <= CAUSE_EBREAK;
            halt_idx   <= '0;
            halt_pc    <= pc;
          end else if (bkpt_hit) begin
            halt_cause <= CAUSE_BKPT;
            halt_idx   <= bkpt_hit_idx;
            halt_pc    <= pc;
          end else if (timeout_hit) begin
            halt_cause <= CAUSE_TIMEOUT;
            halt_idx   <= '0;
            halt_pc    <= '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
          halt    <= 1'b0;
        end
      endcase
    end
  end

  mon_trace_fifo #(
    .W     (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk       (clk),
    .rst       (rst),
    .push      ((state == ST_RUN) && pc_valid),
    .push_data (pc),
    .pop       (trace_rd_en),
    .rd_data   (trace_rd_data),
    .count     (trace_count),
    .overflow  (trace_overflow)
  );

endmodule

// File: tb/tb_core_run_monitor.sv
// Self-checking bench for core_run_monitor: directed scenarios followed by a
// randomized phase, all compared every cycle against a behavioural model.
module tb_core_run_monitor;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam int NB    = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        run_start;
  logic        bkpt_we;
  logic [1:0]  bkpt_idx;
  logic [31:0] bkpt_addr;
  logic        bkpt_en;
  logic [15:0] timeout_limit;
  logic        running;
  logic        halt;
  logic [1:0]  halt_cause;
  logic [1:0]  halt_idx;
  logic [31:0] halt_pc;
  logic [15:0] cycle_cnt;
  logic        trace_rd_en;
  logic [31:0] trace_rd_data;
  logic [2:0]  trace_count;
  logic        trace_overflow;

  core_run_monitor #(
    .XLEN(32), .NUM_BKPT(NB), .TRACE_DEPTH(DEPTH), .TIMEOUT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .inst(inst),
    .run_start(run_start), .bkpt_we(bkpt_we), .bkpt_idx(bkpt_idx),
    .bkpt_addr(bkpt_addr), .bkpt_en(bkpt_en), .timeout_limit(timeout_limit),
    .running(running), .halt(halt), .halt_cause(halt_cause), .halt_idx(halt_idx),
    .halt_pc(halt_pc), .cycle_cnt(cycle_cnt), .trace_rd_en(trace_rd_en),
    .trace_rd_data(trace_rd_data), .trace_count(trace_count),
    .trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: 0 = idle, 1 = run, 2 = halted.
  int          m_state;
  int          m_cnt;
  int          m_cause;
  int          m_idx;
  logic [31:0] m_hpc;
  logic [31:0] m_bk_addr [NB];
  bit          m_bk_en   [NB];
  logic [31:0] m_q [$];
  bit          m_ovf;

  task automatic model_step();
    bit push;
    int cause;
    int idx;
    logic [31:0] hp;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_cause = 0; m_idx = 0; m_hpc = 0; m_ovf = 0;
      m_q.delete();
      for (int i = 0; i < NB; i++) begin m_bk_addr[i] = 0; m_bk_en[i] = 0; end
      return;
    end
    push = (m_state == 1) && pc_valid;
    if (m_state == 1) begin
      cause = 0; idx = 0; hp = 0;
      if (pc_valid && inst == EBREAK) begin
        cause = 1; hp = pc;
      end else begin
        for (int i = 0; i < NB; i++)
          if (cause == 0 && pc_valid && m_bk_en[i] && m_bk_addr[i] == pc) begin
            cause = 2; idx = i; hp = pc;
          end
        if (cause == 0 && timeout_limit != 0 && m_cnt == int'(timeout_limit) - 1) cause = 3;
      end
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (cause != 0) begin
        m_state = 2; m_cause = cause; m_idx = idx; m_hpc = hp;
      end
    end else if (run_start) begin
      m_state = 1; m_cnt = 0; m_cause = 0; m_idx = 0; m_hpc = 0;
    end
    if (trace_rd_en && m_q.size() > 0) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back(pc);
      if (m_q.size() > DEPTH) begin
        void'(m_q.pop_front());
        m_ovf = 1;
      end
    end
    if (bkpt_we) begin
      m_bk_addr[bkpt_idx] = bkpt_addr;
      m_bk_en[bkpt_idx]   = bkpt_en;
    end
  endtask

  task automatic compare_all();
    check_eq("running", running, m_state == 1);
    check_eq("halt", halt, m_state == 2);
    check_eq("halt_cause", halt_cause, m_cause);
    check_eq("halt_idx", halt_idx, m_idx);
    check_eq("halt_pc", halt_pc, m_hpc);
    check_eq("cycle_cnt", cycle_cnt, m_cnt);
    check_eq("trace_count", trace_count, m_q.size());
    check_eq("trace_rd_data", trace_rd_data, (m_q.size() > 0) ? m_q[0] : 32'h0);
    check_eq("trace_overflow", trace_overflow, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    pc_valid = 0; pc = 0; inst = 32'h13; run_start = 0; bkpt_we = 0;
    bkpt_idx = 0; bkpt_addr = 0; bkpt_en = 0; trace_rd_en = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
  endtask

  task automatic write_bkpt(input int idx, input logic [31:0] addr, input bit en);
    bkpt_we = 1; bkpt_idx = 2'(idx); bkpt_addr = addr; bkpt_en = en;
    step();
    bkpt_we = 0;
  endtask

  task automatic start_run();
    run_start = 1;
    step();
    run_start = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    timeout_limit = 0;
    step(); step();
    check_eq("rst_running", running, 0);
    check_eq("rst_halt", halt, 0);
    check_eq("rst_count", trace_count, 0);
    rst = 0;

    // Start with nothing happening, then a short pc stream.
    step();
    start_run();
    check_eq("start_running", running, 1);
    check_eq("start_halt", halt, 0);
    for (int k = 0; k < 3; k++) begin
      pc_valid = 1; pc = 32'(k * 4);
      step();
      check_eq("trace_grows", trace_count, k + 1);
    end

    // Breakpoint in slot 2.
    do_reset();
    write_bkpt(2, 32'h33C, 1);
    start_run();
    for (int p = 0; p <= 32'h400; p += 4) begin
      pc_valid = 1; pc = 32'(p);
      step();
      if (m_state == 2) break;
    end
    pc_valid = 0;
    check_eq("bk_halt", halt, 1);
    check_eq("bk_cause", halt_cause, 2);
    check_eq("bk_idx", halt_idx, 2);
    check_eq("bk_pc", halt_pc, 32'h33C);
    trace_rd_en = 1;
    step(); step(); step();
    trace_rd_en = 0;
    check_eq("bk_last_trace", trace_rd_data, 32'h33C);

    // ebreak outranks two matching breakpoints.
    do_reset();
    write_bkpt(0, 32'h100, 1);
    write_bkpt(1, 32'h100, 1);
    start_run();
    for (int p = 0; p <= 32'h200; p += 4) begin
      pc_valid = 1; pc = 32'(p);
      inst = (p == 32'h100) ? EBREAK : 32'h13;
      step();
      if (m_state == 2) break;
    end
    pc_valid = 0; inst = 32'h13;
    check_eq("eb_cause", halt_cause, 1);
    check_eq("eb_pc", halt_pc, 32'h100);

    // Timeout of 5 RUN cycles, then resume.
    do_reset();
    timeout_limit = 5;
    start_run();
    for (int k = 0; k < 20 && m_state != 2; k++) step();
    check_eq("to_halt", halt, 1);
    check_eq("to_cause", halt_cause, 3);
    check_eq("to_cnt", cycle_cnt, 5);
    check_eq("to_pc", halt_pc, 0);
    step();
    check_eq("to_cnt_hold", cycle_cnt, 5);
    timeout_limit = 0;
    start_run();
    check_eq("resume_running", running, 1);
    check_eq("resume_halt", halt, 0);
    check_eq("resume_cnt", cycle_cnt, 0);
    check_eq("resume_cause", halt_cause, 0);

    // Trace overflow with 6 pushes into a 4-deep buffer.
    do_reset();
    start_run();
    for (int k = 0; k < 6; k++) begin
      pc_valid = 1; pc = 32'h10 + 32'(k * 4);
      step();
    end
    pc_valid = 0;
    check_eq("ovf_count", trace_count, 4);
    check_eq("ovf_flag", trace_overflow, 1);
    trace_rd_en = 1;
    for (int k = 0; k < 4; k++) begin
      check_eq("ovf_pop_data", trace_rd_data, 32'h18 + 32'(k * 4));
      step();
    end
    check_eq("ovf_empty", trace_count, 0);
    step();
    trace_rd_en = 0;
    check_eq("pop_empty_count", trace_count, 0);
    check_eq("pop_empty_data", trace_rd_data, 0);

    // Reset mid-run with a full trace and an armed breakpoint.
    do_reset();
    write_bkpt(0, 32'h40, 1);
    start_run();
    for (int k = 0; k < 5; k++) begin
      pc_valid = 1; pc = 32'h80 + 32'(k * 4);
      step();
    end
    check_eq("pre_rst_count", trace_count, 4);
    rst = 1;
    step();
    rst = 0; pc_valid = 0;
    check_eq("mid_rst_running", running, 0);
    check_eq("mid_rst_count", trace_count, 0);
    check_eq("mid_rst_ovf", trace_overflow, 0);
    start_run();
    pc_valid = 1; pc = 32'h40;
    step();
    pc_valid = 0;
    step();
    check_eq("bkpt_cleared", halt, 0);

    // Randomized phase.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      rst         = ($urandom_range(0, 299) == 0);
      run_start   = ($urandom_range(0, 7) == 0);
      pc_valid    = $urandom_range(0, 1);
      pc          = 32'($urandom_range(0, 15) * 4);
      inst        = ($urandom_range(0, 39) == 0) ? EBREAK : 32'($urandom);
      bkpt_we     = ($urandom_range(0, 9) == 0);
      bkpt_idx    = 2'($urandom_range(0, 3));
      bkpt_addr   = 32'($urandom_range(0, 15) * 4);
      bkpt_en     = ($urandom_range(0, 3) != 0);
      trace_rd_en = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) timeout_limit = 16'($urandom_range(0, 30));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
